// File: rtl/mobo_readout_fsm.sv
// mobo_readout_fsm: responder side of the FSMIND exposure/readout handshake,
// sequencing per-row pixel and TI-ADC timing, then handing control back.
module mobo_readout_fsm #(
  parameter int          C_NUM_ROWS   = 160,
  parameter int          C_T_SETTLE   = 20,
  parameter int          C_T_SMPL     = 10,
  parameter int          C_T_RST      = 10,
  parameter int          C_ADC_TMO    = 1000,
  parameter logic [15:0] C_FRAME_INIT = 16'h0000
) (
  input  logic        CLK_HS,
  input  logic        RESET_B,
  input  logic        FSMIND1,
  output logic        FSMIND1ACK,
  output logic        FSMIND0,
  input  logic        FSMIND0ACK,
  input  logic        ADC_DONE,
  output logic [7:0]  ROW_ADDR,
  output logic        ROW_EN,
  output logic        SMPL_SIG,
  output logic        ROW_RST,
  output logic        SMPL_RST,
  output logic        ADC_START,
  output logic        ADC_TMO_ERR,
  output logic [15:0] FRAME_CNT,
  output logic [8:1]  fsm_stat
);
  // state encodings double as the fsm_stat codes, so fsm_stat is the state register
  typedef enum logic [7:0] {
    S_IDLE   = 8'hF0,
    S_ACK    = 8'hF1,
    S_SETTLE = 8'hF2,
    S_SIG    = 8'hF3,
    S_RST    = 8'hF4,
    S_SRST   = 8'hF5,
    S_CONV   = 8'hF6,
    S_WAIT   = 8'hF7,
    S_HBACK  = 8'hF8,
    S_DONE   = 8'hF9
  } state_t;
  state_t      state;
  logic [15:0] cnt;
  logic        s1_m, s1, s0a_m, s0a;
  assign fsm_stat = state;
  always_ff @(posedge CLK_HS or negedge RESET_B) begin
    if (!RESET_B) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      {s1_m, s1, s0a_m, s0a} <= 4'b0;
      FSMIND1ACK  <= 1'b0;
      FSMIND0     <= 1'b0;
      ROW_ADDR    <= 8'd0;
      ROW_EN      <= 1'b0;
      SMPL_SIG    <= 1'b0;
      ROW_RST     <= 1'b0;
      SMPL_RST    <= 1'b0;
      ADC_START   <= 1'b0;
      ADC_TMO_ERR <= 1'b0;
      FRAME_CNT   <= C_FRAME_INIT;
    end else begin
      s1_m  <= FSMIND1;
      s1    <= s1_m;
      s0a_m <= FSMIND0ACK;
      s0a   <= s0a_m;
      case (state)
        S_IDLE: if (s1) state <= S_ACK;
        S_ACK: begin
          FSMIND1ACK <= 1'b1;
          ROW_ADDR   <= 8'd0;
          ROW_EN     <= 1'b1;
          cnt        <= 16'd0;
          state      <= S_SETTLE;
        end
        S_SETTLE:
          if (cnt == 16'(C_T_SETTLE - 1)) begin
            cnt      <= 16'd0;
            SMPL_SIG <= 1'b1;
            state    <= S_SIG;
          end else cnt <= cnt + 16'd1;
        S_SIG:
          if (cnt == 16'(C_T_SMPL - 1)) begin
            cnt      <= 16'd0;
            SMPL_SIG <= 1'b0;
            ROW_RST  <= 1'b1;
            state    <= S_RST;
          end else cnt <= cnt + 16'd1;
        S_RST:
          if (cnt == 16'(C_T_RST - 1)) begin
            cnt      <= 16'd0;
            ROW_RST  <= 1'b0;
            SMPL_RST <= 1'b1;
            state    <= S_SRST;
          end else cnt <= cnt + 16'd1;
        S_SRST:
          if (cnt == 16'(C_T_SMPL - 1)) begin
            cnt       <= 16'd0;
            SMPL_RST  <= 1'b0;
            ADC_START <= 1'b1;
            state     <= S_CONV;
          end else cnt <= cnt + 16'd1;
        S_CONV: begin
          ADC_START <= 1'b0;
          cnt       <= 16'd0;
          state     <= S_WAIT;
        end
        // a DONE arriving on the timeout cycle wins, so no error is flagged
        S_WAIT:
          if (ADC_DONE || cnt == 16'(C_ADC_TMO - 1)) begin
            cnt <= 16'd0;
            if (!ADC_DONE) ADC_TMO_ERR <= 1'b1;
            if (ROW_ADDR < 8'(C_NUM_ROWS - 1)) begin
              ROW_ADDR <= ROW_ADDR + 8'd1;
              state    <= S_SETTLE;
            end else begin
              ROW_EN    <= 1'b0;
              FSMIND0   <= 1'b1;
              FRAME_CNT <= FRAME_CNT + 16'd1;
              state     <= S_HBACK;
            end
          end else cnt <= cnt + 16'd1;
        S_HBACK: begin
          if (!s1) FSMIND1ACK <= 1'b0;
          if (s0a && !s1) state <= S_DONE;
        end
        S_DONE: begin
          FSMIND0    <= 1'b0;
          FSMIND1ACK <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mobo_readout_fsm.sv
// tb_mobo_readout_fsm: directed frames with a row-address scoreboard, ADC responder
// and per-cycle invariant checks; a second instance preloaded to 0xFFFF checks wrap.
module tb_mobo_readout_fsm;
  localparam int NR = 4;
  logic CLK_HS = 0, RESET_B = 0, FSMIND1 = 0, FSMIND0ACK = 0, ADC_DONE = 0;
  logic FSMIND1ACK, FSMIND0, ROW_EN, SMPL_SIG, ROW_RST, SMPL_RST, ADC_START, ADC_TMO_ERR;
  logic [7:0] ROW_ADDR, fsm_stat;
  logic [15:0] FRAME_CNT;
  logic x_ack, x_ind0, x_en, x_sig, x_rst, x_srst, x_start, x_err;
  logic [7:0] x_row, x_stat;
  logic [15:0] x_frame;
  mobo_readout_fsm #(.C_NUM_ROWS(NR), .C_T_SETTLE(20), .C_T_SMPL(10), .C_T_RST(10),
                     .C_ADC_TMO(1000)) dut (
    .CLK_HS(CLK_HS), .RESET_B(RESET_B), .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK), .ADC_DONE(ADC_DONE), .ROW_ADDR(ROW_ADDR),
    .ROW_EN(ROW_EN), .SMPL_SIG(SMPL_SIG), .ROW_RST(ROW_RST), .SMPL_RST(SMPL_RST),
    .ADC_START(ADC_START), .ADC_TMO_ERR(ADC_TMO_ERR), .FRAME_CNT(FRAME_CNT),
    .fsm_stat(fsm_stat));
  mobo_readout_fsm #(.C_NUM_ROWS(NR), .C_T_SETTLE(20), .C_T_SMPL(10), .C_T_RST(10),
                     .C_ADC_TMO(1000), .C_FRAME_INIT(16'hFFFF)) dut_wrap (
    .CLK_HS(CLK_HS), .RESET_B(RESET_B), .FSMIND1(FSMIND1), .FSMIND1ACK(x_ack),
    .FSMIND0(x_ind0), .FSMIND0ACK(FSMIND0ACK), .ADC_DONE(ADC_DONE), .ROW_ADDR(x_row),
    .ROW_EN(x_en), .SMPL_SIG(x_sig), .ROW_RST(x_rst), .SMPL_RST(x_srst),
    .ADC_START(x_start), .ADC_TMO_ERR(x_err), .FRAME_CNT(x_frame), .fsm_stat(x_stat));
  always #5 CLK_HS = ~CLK_HS;
  int vectors = 0, miscompares = 0;
  int cyc = 0, last_start = 0, starts = 0, exp_period = 56, adc_delay = 5, dcnt = 0;
  bit adc_never = 0, fsmind0_seen = 0;
  logic [7:0] exp_rows[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {FSMIND1ACK, FSMIND0, ROW_EN, SMPL_SIG, ROW_RST, SMPL_RST, ADC_START,
              ADC_TMO_ERR, ROW_ADDR, FRAME_CNT}, 32'd0);
    chk({tag, "_stat"}, 32'(fsm_stat), 32'hF0);
  endtask
  task automatic wait_stat(input logic [7:0] code, input int max, input string tag);
    int n = 0;
    do begin
      @(negedge CLK_HS);
      n++;
    end while (fsm_stat !== code && n < max);
    chk(tag, 32'(fsm_stat), 32'(code));
  endtask
  task automatic frame_start();
    for (int r = 0; r < NR; r++) exp_rows.push_back(8'(r));
    starts = 0;
    fsmind0_seen = 0;
    FSMIND1 = 1;
  endtask
  task automatic handback(input string tag);
    FSMIND1 = 0;
    repeat (6) @(negedge CLK_HS);
    chk({tag, "_hold"}, 32'(fsm_stat), 32'hF8);
    chk({tag, "_ackdrop"}, 32'(FSMIND1ACK), 32'd0);
    FSMIND0ACK = 1;
    wait_stat(8'hF0, 20, {tag, "_idle"});
    chk({tag, "_ind0"}, 32'(FSMIND0), 32'd0);
    FSMIND0ACK = 0;
    repeat (4) @(negedge CLK_HS);
  endtask
  always @(posedge CLK_HS) cyc++;
  // monitor and ADC responder: DONE lands adc_delay cycles after the START cycle
  always @(negedge CLK_HS) begin
    chk("invariants", {29'd0, $onehot0({SMPL_SIG, ROW_RST, SMPL_RST, ADC_START}),
        ROW_ADDR <= 8'(NR - 1), !(FSMIND0 && fsm_stat == 8'hF0)}, 32'd7);
    if (FSMIND0) fsmind0_seen = 1;
    if (ADC_START) begin
      starts++;
      if (exp_rows.size() == 0) chk("sb_underflow", 32'(exp_rows.size()), 32'd1);
      else chk("row_addr", 32'(ROW_ADDR), 32'(exp_rows.pop_front()));
      if (ROW_ADDR != 0) chk("row_period", 32'(cyc - last_start), 32'(exp_period));
      last_start = cyc;
    end
    ADC_DONE = 0;
    if (ADC_START) dcnt = adc_delay;
    else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && !adc_never) ADC_DONE = 1;
    end
  end
  initial begin
    repeat (3) @(negedge CLK_HS);
    chk_zero("reset");
    RESET_B = 1;
    repeat (10) @(negedge CLK_HS);
    chk("idle_quiet", {22'd0, FSMIND1ACK, ROW_EN, fsm_stat}, 32'hF0);
    FSMIND1 = 1;
    repeat (3) @(posedge CLK_HS);
    #1 chk("ack_lat_n2", 32'(FSMIND1ACK), 32'd0);
    @(posedge CLK_HS);
    #1 chk("ack_lat_n3", 32'(FSMIND1ACK), 32'd1);
    wait_stat(8'hF3, 100, "reach_sig");
    #1 RESET_B = 0;
    FSMIND1 = 0;
    #1 chk_zero("async_rst");
    @(negedge CLK_HS) RESET_B = 1;
    repeat (20) @(negedge CLK_HS);
    chk("post_rst_quiet", {22'd0, FSMIND1ACK, ROW_EN, fsm_stat}, 32'hF0);
    frame_start();
    wait_stat(8'hF8, 400, "nom_hback");
    chk("nom_starts", 32'(starts), 32'(NR));
    chk("nom_sb_empty", 32'(exp_rows.size()), 32'd0);
    chk("nom_outs", {28'd0, ROW_EN, FSMIND0, FSMIND1ACK, ADC_TMO_ERR}, 32'b0110);
    chk("nom_frames", 32'(FRAME_CNT), 32'd1);
    chk("wrap_frames", 32'(x_frame), 32'd0);
    handback("nom");
    FSMIND0ACK = 1;
    frame_start();
    wait_stat(8'hF8, 400, "ord_hback");
    repeat (20) @(negedge CLK_HS);
    chk("ord_stuck", {22'd0, FSMIND1ACK, FSMIND0, fsm_stat}, 32'h3F8);
    FSMIND1 = 0;
    wait_stat(8'hF9, 10, "ord_done");
    @(negedge CLK_HS);
    chk("ord_idle", {22'd0, FSMIND1ACK, FSMIND0, fsm_stat}, 32'hF0);
    chk("ord_frames", 32'(FRAME_CNT), 32'd2);
    FSMIND0ACK = 0;
    repeat (2) @(negedge CLK_HS);
    frame_start();
    wait_stat(8'hF2, 10, "b2b_start");
    chk("b2b_ack", 32'(FSMIND1ACK), 32'd1);
    wait_stat(8'hF8, 400, "b2b_hback");
    chk("b2b_frames", 32'(FRAME_CNT), 32'd3);
    handback("b2b");
    adc_delay = 1000;
    exp_period = 1051;
    frame_start();
    wait_stat(8'hF8, 5000, "edge_hback");
    chk("edge_no_err", 32'(ADC_TMO_ERR), 32'd0);
    chk("edge_starts", 32'(starts), 32'(NR));
    handback("edge");
    adc_never = 1;
    frame_start();
    wait_stat(8'hF8, 5000, "tmo_hback");
    chk("tmo_err", 32'(ADC_TMO_ERR), 32'd1);
    chk("tmo_starts", 32'(starts), 32'(NR));
    chk("tmo_sb_empty", 32'(exp_rows.size()), 32'd0);
    chk("tmo_frames", 32'(FRAME_CNT), 32'd5);
    handback("tmo");
    adc_never = 0;
    adc_delay = 5;
    exp_period = 56;
    frame_start();
    wait_stat(8'hF8, 400, "sticky_hback");
    chk("sticky_err", 32'(ADC_TMO_ERR), 32'd1);
    handback("sticky");
    frame_start();
    for (int n = 0; n < 300 && ROW_ADDR != 8'd2; n++) @(negedge CLK_HS);
    chk("abort_row", 32'(ROW_ADDR), 32'd2);
    #1 RESET_B = 0;
    FSMIND1 = 0;
    exp_rows.delete();
    #1 chk_zero("abort_rst");
    @(negedge CLK_HS) RESET_B = 1;
    repeat (200) @(negedge CLK_HS);
    chk("abort_no_hback", 32'(fsmind0_seen), 32'd0);
    chk("abort_idle", 32'(fsm_stat), 32'hF0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
